beat_interval_bpm: RTL and testbench

- Downstream of the peak finder in the heart-rate chain.
- Timestamps each rising edge of the peak flag in units of filtered-sample periods and rejects implausible inter-beat intervals.
- Averages the last four accepted intervals and converts the average to beats per minute with a sequential divider.
- Produces binary BPM plus 3-digit BCD for the seven-segment mux, replacing the fixed 10 s peak-count window with per-beat updates.

---
 rtl/hr_pkg.sv | 34 +++
 rtl/seq_divider.sv | 85 ++++++++
 rtl/beat_interval_bpm.sv | 242 ++++++++++++++++++++++++
 tb/tb_beat_interval_bpm.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hr_pkg.sv
// rtl/hr_pkg.sv - shared constants, state encodings and derivations for the beat-interval BPM block
package hr_pkg;

    // Interval measurement: wait for the first beat, then track beat-to-beat spacing
    typedef enum logic [0:0] {
        WAIT_FIRST = 1'b0,
        TRACK      = 1'b1
    } meas_state_t;

    // BPM computation: divide, convert to BCD, return to idle
    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_DIV  = 2'd1,
        C_BCD  = 2'd2
    } comp_state_t;

    // Samples per minute; the dividend that turns an interval into BPM
    function automatic int unsigned calc_k(input int unsigned sample_rate);
        return sample_rate * 60;
    endfunction

    // Shortest plausible interval (fastest rate), truncated
    function automatic int unsigned calc_min_int(input int unsigned sample_rate,
                                                 input int unsigned max_bpm);
        return calc_k(sample_rate) / max_bpm;
    endfunction

    // Longest plausible interval (slowest rate); reaching it without a beat is a timeout
    function automatic int unsigned calc_max_int(input int unsigned sample_rate,
                                                 input int unsigned min_bpm);
        return calc_k(sample_rate) / min_bpm;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per clock, start/done handshake
module seq_divider #(
    parameter int unsigned W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W:0]    rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] iter_q, iter_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W:0]    shifted;
    logic [W:0]    trial;

    assign quotient = quo_q;
    assign done     = done_q;

    // One restoring step per cycle; the dividend register shifts out MSB-first and fills with quotient bits
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        shifted = {rem_q[W-1:0], quo_q[W-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            iter_d = CW'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            // A set top bit means the trial subtraction went negative: restore
            if (trial[W]) begin
                rem_d = shifted;
                quo_d = {quo_q[W-2:0], 1'b0};
            end else begin
                rem_d = trial;
                quo_d = {quo_q[W-2:0], 1'b1};
            end
            iter_d = iter_q - CW'(1);
            if (iter_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
        if (abort) begin
            busy_d = 1'b0;
            done_d = 1'b0;
        end
    end

    // Divider state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            iter_q <= iter_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/beat_interval_bpm.sv
// rtl/beat_interval_bpm.sv - beat interval measurement, 4-beat average and BPM/BCD conversion
module beat_interval_bpm #(
    parameter int unsigned SAMPLE_RATE = 78125,
    parameter int unsigned MIN_BPM     = 30,
    parameter int unsigned MAX_BPM     = 220,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned DIV_W       = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_en,
    input  logic        peak,
    output logic [7:0]  bpm,
    output logic [11:0] bpm_bcd,
    output logic        bpm_valid,
    output logic        locked,
    output logic        beat
);

    import hr_pkg::*;

    localparam int unsigned K       = calc_k(SAMPLE_RATE);
    localparam int unsigned MIN_INT = calc_min_int(SAMPLE_RATE, MAX_BPM);
    localparam int unsigned MAX_INT = calc_max_int(SAMPLE_RATE, MIN_BPM);
    localparam int unsigned SUM_W   = CNT_W + 2;

    localparam logic [CNT_W-1:0] MIN_INT_C = CNT_W'(MIN_INT);
    localparam logic [CNT_W-1:0] MAX_INT_C = CNT_W'(MAX_INT);
    localparam logic [DIV_W-1:0] K_C       = DIV_W'(K);

    // Add-3 on every BCD digit that is 5 or more, then shift in the next binary bit
    function automatic logic [11:0] dabble_step(input logic [11:0] b, input logic bit_in);
        logic [11:0] t;
        t = b;
        if (t[3:0]  >= 4'd5) t[3:0]  = t[3:0]  + 4'd3;
        if (t[7:4]  >= 4'd5) t[7:4]  = t[7:4]  + 4'd3;
        if (t[11:8] >= 4'd5) t[11:8] = t[11:8] + 4'd3;
        return {t[10:0], bit_in};
    endfunction

    // Measurement side
    meas_state_t      meas_state_q, meas_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_peak_q, prev_peak_d;
    logic [CNT_W-1:0] hist_q [4];
    logic [CNT_W-1:0] hist_d [4];
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             locked_q, locked_d;
    logic             beat_q, beat_d;
    logic             req_q, req_d;
    logic             rise;
    logic             accept;
    logic             timeout;

    // Compute side
    comp_state_t      comp_state_q, comp_state_d;
    logic [7:0]       quot_q, quot_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [2:0]       step_q, step_d;
    logic [7:0]       bpm_q, bpm_d;
    logic [11:0]      bcd_out_q, bcd_out_d;
    logic             valid_q, valid_d;
    logic             div_start;
    logic             div_done;
    logic [DIV_W-1:0] div_quot;
    logic [DIV_W-1:0] div_divisor;
    logic [11:0]      dabble;

    assign bpm       = bpm_q;
    assign bpm_bcd   = bcd_out_q;
    assign bpm_valid = valid_q;
    assign locked    = locked_q;
    assign beat      = beat_q;

    assign rise        = sample_en & peak & ~prev_peak_q;
    assign div_divisor = DIV_W'(sum_q >> 2);
    assign div_start   = (comp_state_q == C_IDLE) && req_q && !timeout;
    assign dabble      = dabble_step(bcd_q, quot_q[3'd7 - step_q]);

    // Classify each sampled beat against the running interval and maintain the 4-entry history
    always_comb begin
        meas_state_d = meas_state_q;
        cnt_d        = cnt_q;
        prev_peak_d  = prev_peak_q;
        hist_d       = hist_q;
        sum_d        = sum_q;
        locked_d     = locked_q;
        beat_d       = 1'b0;
        accept       = 1'b0;
        timeout      = 1'b0;
        if (sample_en) begin
            prev_peak_d = peak;
            case (meas_state_q)
                WAIT_FIRST: begin
                    // First beat only starts the clock; no interval exists yet
                    if (rise) begin
                        cnt_d        = CNT_W'(1);
                        meas_state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (rise && cnt_q >= MIN_INT_C && cnt_q <= MAX_INT_C) begin
                        accept   = 1'b1;
                        beat_d   = 1'b1;
                        cnt_d    = CNT_W'(1);
                        locked_d = 1'b1;
                        if (!locked_q) begin
                            // Seed the whole history so the first average is this interval
                            for (int i = 0; i < 4; i++) hist_d[i] = cnt_q;
                            sum_d = {cnt_q, 2'b00};
                        end else begin
                            hist_d[0] = cnt_q;
                            hist_d[1] = hist_q[0];
                            hist_d[2] = hist_q[1];
                            hist_d[3] = hist_q[2];
                            sum_d     = sum_q + {2'b00, cnt_q} - {2'b00, hist_q[3]};
                        end
                    end else if (cnt_q >= MAX_INT_C) begin
                        // Too long without a plausible beat: drop everything and resynchronise
                        timeout      = 1'b1;
                        meas_state_d = WAIT_FIRST;
                        locked_d     = 1'b0;
                        cnt_d        = '0;
                        sum_d        = '0;
                        for (int i = 0; i < 4; i++) hist_d[i] = '0;
                    end else begin
                        // Normal counting; early (double-detect) beats land here too
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: meas_state_d = WAIT_FIRST;
            endcase
        end
    end

    // Single-deep request: a beat accepted while busy leaves it set for the next run
    always_comb begin
        req_d = req_q;
        if (div_start) req_d = 1'b0;
        if (accept)    req_d = 1'b1;
        if (timeout)   req_d = 1'b0;
    end

    // Sequence divide then double-dabble; timeout overrides any result in the same cycle
    always_comb begin
        comp_state_d = comp_state_q;
        quot_d       = quot_q;
        bcd_d        = bcd_q;
        step_d       = step_q;
        bpm_d        = bpm_q;
        bcd_out_d    = bcd_out_q;
        valid_d      = 1'b0;
        case (comp_state_q)
            C_IDLE: begin
                if (div_start) comp_state_d = C_DIV;
            end
            C_DIV: begin
                if (div_done) begin
                    quot_d       = (|div_quot[DIV_W-1:8]) ? 8'hFF : div_quot[7:0];
                    bcd_d        = '0;
                    step_d       = '0;
                    comp_state_d = C_BCD;
                end
            end
            C_BCD: begin
                bcd_d  = dabble;
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    bpm_d        = quot_q;
                    bcd_out_d    = dabble;
                    valid_d      = 1'b1;
                    comp_state_d = C_IDLE;
                end
            end
            default: comp_state_d = C_IDLE;
        endcase
        if (timeout) begin
            comp_state_d = C_IDLE;
            bpm_d        = '0;
            bcd_out_d    = '0;
            valid_d      = 1'b0;
        end
    end

    // Measurement registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meas_state_q <= WAIT_FIRST;
            cnt_q        <= '0;
            prev_peak_q  <= 1'b0;
            hist_q       <= '{default: '0};
            sum_q        <= '0;
            locked_q     <= 1'b0;
            beat_q       <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            meas_state_q <= meas_state_d;
            cnt_q        <= cnt_d;
            prev_peak_q  <= prev_peak_d;
            hist_q       <= hist_d;
            sum_q        <= sum_d;
            locked_q     <= locked_d;
            beat_q       <= beat_d;
            req_q        <= req_d;
        end
    end

    // Compute and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            comp_state_q <= C_IDLE;
            quot_q       <= '0;
            bcd_q        <= '0;
            step_q       <= '0;
            bpm_q        <= '0;
            bcd_out_q    <= '0;
            valid_q      <= 1'b0;
        end else begin
            comp_state_q <= comp_state_d;
            quot_q       <= quot_d;
            bcd_q        <= bcd_d;
            step_q       <= step_d;
            bpm_q        <= bpm_d;
            bcd_out_q    <= bcd_out_d;
            valid_q      <= valid_d;
        end
    end

    seq_divider #(
        .W(DIV_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .abort    (timeout),
        .dividend (K_C),
        .divisor  (div_divisor),
        .quotient (div_quot),
        .done     (div_done)
    );

endmodule

// File: tb/tb_beat_interval_bpm.sv
// tb/tb_beat_interval_bpm.sv - self-checking bench for beat_interval_bpm
module tb_beat_interval_bpm;

    localparam int SR      = 100;
    localparam int K       = SR * 60;
    localparam int MIN_INT = K / 220;
    localparam int MAX_INT = K / 30;
    localparam int LAT     = 34;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_en = 1'b1;
    logic        peak = 1'b0;
    logic [7:0]  bpm;
    logic [11:0] bpm_bcd;
    logic        bpm_valid;
    logic        locked;
    logic        beat;

    beat_interval_bpm #(
        .SAMPLE_RATE(SR),
        .MIN_BPM(30),
        .MAX_BPM(220),
        .CNT_W(20),
        .DIV_W(24)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .peak      (peak),
        .bpm       (bpm),
        .bpm_bcd   (bpm_bcd),
        .bpm_valid (bpm_valid),
        .locked    (locked),
        .beat      (beat)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // Behavioural model: sample indices, a queue of intervals, and a scheduled result
    int  cyc = 0;
    bit  m_track, m_locked, m_prev, m_busy, m_req;
    int  m_samp, m_ref, m_fin, m_res, m_sum, m_gap;
    int  m_hist[$];
    int  e_bpm;
    bit  e_valid, e_beat;
    bit  m_rise;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_track = 0; m_locked = 0; m_prev = 0; m_busy = 0; m_req = 0;
            m_samp = 0; m_ref = 0; m_hist.delete();
            e_bpm = 0; e_valid = 0; e_beat = 0;
        end else begin
            cyc++;
            e_valid = 0;
            e_beat  = 0;
            if (m_busy && cyc == m_fin) begin
                e_valid = 1; e_bpm = m_res; m_busy = 0;
            end else if (!m_busy && m_req) begin
                m_sum = 0;
                foreach (m_hist[i]) m_sum += m_hist[i];
                m_res = K / (m_sum / 4);
                if (m_res > 255) m_res = 255;
                m_busy = 1; m_fin = cyc + LAT - 1; m_req = 0;
            end
            if (sample_en) begin
                m_samp++;
                m_rise = peak && !m_prev;
                m_prev = peak;
                if (!m_track) begin
                    if (m_rise) begin m_track = 1; m_ref = m_samp; end
                end else begin
                    m_gap = m_samp - m_ref;
                    if (m_rise && m_gap >= MIN_INT && m_gap <= MAX_INT) begin
                        e_beat = 1;
                        if (!m_locked) begin
                            m_hist.delete();
                            for (int i = 0; i < 4; i++) m_hist.push_back(m_gap);
                        end else begin
                            m_hist.push_front(m_gap);
                            void'(m_hist.pop_back());
                        end
                        m_locked = 1; m_req = 1; m_ref = m_samp;
                    end else if (m_gap == MAX_INT) begin
                        m_track = 0; m_locked = 0; m_hist.delete();
                        m_busy = 0; m_req = 0;
                        e_bpm = 0; e_valid = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus event bookkeeping for literal checks
    int n_valid = 0, n_beat = 0;
    int last_beat_cyc = 0, last_valid_cyc = 0;
    int vals[$];

    always @(negedge clk) begin
        chk("bpm", bpm, e_bpm);
        chk("bpm_bcd", bpm_bcd, to_bcd(e_bpm));
        chk("bpm_valid", bpm_valid, e_valid);
        chk("locked", locked, m_locked);
        chk("beat", beat, e_beat);
        if (bpm_valid === 1'b1) begin n_valid++; last_valid_cyc = cyc; vals.push_back(int'(bpm)); end
        if (beat === 1'b1) begin n_beat++; last_beat_cyc = cyc; end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse();
        peak = 1'b1;
        step();
        peak = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " bpm"}, bpm, 0);
        chk({tag, " bcd"}, bpm_bcd, 0);
        chk({tag, " valid"}, bpm_valid, 0);
        chk({tag, " locked"}, locked, 0);
        chk({tag, " beat"}, beat, 0);
    endtask

    int base, vbase;

    initial begin
        idle(3);
        #1 reset = 1'b0;
        step();
        chk_zero("reset");

        // 60 BPM: first beat silent, second accepted
        pulse(); idle(99); pulse(); idle(40);
        chk("A bpm", bpm, 60);
        chk("A bcd", bpm_bcd, 12'h060);
        chk("A locked", locked, 1);
        chk("A latency", last_valid_cyc - last_beat_cyc, LAT);

        // Interval 60 after three of 100 -> avg 90 -> 66; extra peak 6 samples later ignored
        idle(19); pulse(); idle(5);
        base = n_beat;
        pulse(); idle(40);
        chk("B bpm", bpm, 66);
        chk("B bcd", bpm_bcd, 12'h066);
        idle(53); pulse(); idle(2);
        chk("B reject beats", n_beat - base, 1);
        idle(97); pulse(); idle(99); pulse(); idle(99); pulse(); idle(40);
        chk("C bpm", bpm, 60);

        // Timeout after MAX_INT samples without a beat
        vbase = n_valid;
        idle(170);
        chk("T locked", locked, 0);
        chk("T bpm", bpm, 0);
        chk("T bcd", bpm_bcd, 0);
        chk("T no valid", n_valid - vbase, 0);

        // Relock at interval 80 -> 75; a 20-sample peak is rejected
        pulse(); idle(79); pulse();
        vbase = n_valid;
        idle(19); pulse(); idle(50);
        chk("D bpm", bpm, 75);
        chk("D bcd", bpm_bcd, 12'h075);
        chk("D valids", n_valid - vbase, 1);
        chk("D latency", last_valid_cyc - last_beat_cyc, LAT);

        // Accept during a running compute -> second result from the latest sum
        idle(29); pulse();
        vbase = n_valid;
        base  = vals.size();
        idle(29); pulse(); idle(80);
        chk("P valids", n_valid - vbase, 2);
        if (vals.size() >= base + 2) begin
            chk("P first", vals[base], 70);
            chk("P second", vals[base + 1], 83);
        end else begin
            chk("P results present", vals.size() - base, 2);
        end

        // Reset while the divider is running
        pulse(); idle(10);
        #1 reset = 1'b1;
        #1 chk_zero("midreset");
        idle(3);
        #1 reset = 1'b0;
        base = n_beat;
        pulse(); idle(89); pulse(); idle(40);
        chk("R bpm", bpm, 66);
        chk("R beats", n_beat - base, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
